// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the configurable SPI master.
//   spi_state_e   frame sequencer states
//   MODE_CPOL/CPHA bit positions inside the 2-bit mode word {CPOL, CPHA}
//   *_MIN/*_MAX   supported parameter ranges
//   cs_width()    chip-select index width, never below one bit
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  localparam int MODE_CPOL = 1;
  localparam int MODE_CPHA = 0;

  localparam int DATA_W_MIN = 4;
  localparam int DATA_W_MAX = 32;
  localparam int NUM_CS_MIN = 1;
  localparam int NUM_CS_MAX = 8;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period timer for the SPI master.
//   clk, rst  system clock, async active-high reset
//   en        high while a frame is in progress; low holds the counter at 0
//   half      latched clk_div; a half period lasts half+1 clk cycles
//   tick      high in the last cycle of every half period
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] half,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == half);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (!en || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: single-frame SPI master with per-frame mode, bit order,
// clock divider and slave select, all latched when a start is accepted.
//   clk, rst            system clock, async active-high reset
//   start/ready/busy    handshake; start accepted only while ready
//   mode, lsb_first     {CPOL, CPHA} and bit order for the frame
//   clk_div             half period H = clk_div+1 clk cycles
//   cs_sel              target slave; out-of-range selects nobody
//   tx_data             frame to send
//   rx_data, rx_valid   received frame and its one-cycle completion pulse
//   sclk, mosi, cs_n    SPI bus outputs (all registered); miso serial input
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DIV_W  = 8,
  parameter  int NUM_CS = 2,
  localparam int CS_W   = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  output logic              busy,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  input  logic              miso
);

  // XFER is 2*DATA_W half periods; hp counts them.
  localparam int              HP_W    = $clog2(2 * DATA_W);
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_W - 1);
  localparam logic [HP_W-1:0] HP_PEN  = HP_W'(2 * DATA_W - 2);

  spi_state_e        state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [1:0]        mode_q, mode_d;
  logic              lsb_q, lsb_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_d;
  logic [NUM_CS-1:0] cs_n_d;
  logic              sclk_d, mosi_d, rx_valid_d, ready_d;
  logic              tick, lead_edge, trail_edge, shift_now, sample_now;

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] c;
    c = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (int'(sel) == i) c[i] = 1'b0;
    return c;
  endfunction

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != IDLE),
    .half (div_q),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    mode_d     = mode_q;
    lsb_d      = lsb_q;
    div_d      = div_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sclk_d     = sclk;
    mosi_d     = mosi;
    cs_n_d     = cs_n;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    lead_edge  = 1'b0;
    trail_edge = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        state_d = LEAD;
        hp_d    = '0;
        mode_d  = mode;
        lsb_d   = lsb_first;
        div_d   = clk_div;
        cs_n_d  = cs_decode(cs_sel);
        sclk_d  = mode[MODE_CPOL];
        rx_d    = '0;
        // CPHA=0 needs the first bit on the wire before the first edge;
        // CPHA=1 presents it on the first leading edge instead.
        if (mode[MODE_CPHA]) begin
          mosi_d = 1'b0;
          tx_d   = tx_data;
        end else begin
          mosi_d = first_bit(tx_data, lsb_first);
          tx_d   = shift_out(tx_data, lsb_first);
        end
      end
      LEAD: if (tick) begin
        state_d   = XFER;
        hp_d      = '0;
        sclk_d    = ~sclk;
        lead_edge = 1'b1;
      end
      XFER: if (tick) begin
        // sclk toggles at the start of every half period, so after the
        // last one it is already back at CPOL for TRAIL.
        if (hp_q == HP_LAST) begin
          state_d = TRAIL;
        end else begin
          hp_d   = hp_q + 1'b1;
          sclk_d = ~sclk;
          if (hp_q[0]) lead_edge  = 1'b1;
          else         trail_edge = 1'b1;
        end
      end
      TRAIL: if (tick) begin
        state_d    = IDLE;
        cs_n_d     = '1;
        mosi_d     = 1'b0;
        rx_data_d  = rx_q;
        rx_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // The final trailing edge under CPHA=0 must not shift: the last bit
    // stays on mosi through TRAIL.
    shift_now  = mode_q[MODE_CPHA] ? lead_edge : (trail_edge && (hp_q != HP_PEN));
    sample_now = mode_q[MODE_CPHA] ? trail_edge : lead_edge;

    if (shift_now) begin
      mosi_d = first_bit(tx_q, lsb_q);
      tx_d   = shift_out(tx_q, lsb_q);
    end
    if (sample_now)
      rx_d = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hp_q     <= '0;
      mode_q   <= '0;
      lsb_q    <= 1'b0;
      div_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      mode_q   <= mode_d;
      lsb_q    <= lsb_d;
      div_q    <= div_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      sclk     <= sclk_d;
      mosi     <= mosi_d;
      cs_n     <= cs_n_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      ready    <= ready_d;
      busy     <= ~ready_d;
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg (DATA_W=8, NUM_CS=3). Expected frames go into a
// scoreboard queue at start time; a monitor pops one on every rx_valid and
// compares data and completion cycle. Per-frame bus shape is checked inline.
module tb_spi_master_cfg;

  typedef struct {
    logic [7:0]  data;
    int unsigned due;
  } exp_t;

  logic       clk, rst, start, ready, busy, lsb_first, rx_valid, sclk, mosi, miso, miso_reg;
  logic [1:0] mode, cs_sel;
  logic [7:0] clk_div, tx_data, rx_data;
  logic [2:0] cs_n;
  int         miso_src;
  int unsigned cyc;
  int         errors, checks, frames_seen;
  exp_t       sb[$];

  assign miso = (miso_src == 0) ? mosi : miso_reg;

  spi_master_cfg #(.DATA_W(8), .DIV_W(8), .NUM_CS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .busy(busy),
    .mode(mode), .lsb_first(lsb_first), .clk_div(clk_div), .cs_sel(cs_sel),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rx_valid) begin
        frames_seen++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx_valid: rx_data=0x%0h at cycle %0d, expected no pulse", rx_data, cyc);
        end else begin
          e = sb.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("rx_valid_cycle", cyc, e.due);
        end
      end
    end
  endtask

  // Called at a negedge. Starts one frame, scrambles the inputs while busy,
  // and returns at the negedge of the rx_valid cycle.
  task automatic run_frame(input string nm, input logic [1:0] m, input logic lsb,
                           input logic [7:0] div, input logic [1:0] sel, input logic [7:0] tx,
                           input int msrc, input logic [7:0] mseq, input logic [7:0] exp_rx,
                           input logic exp_first, input int pulse_at);
    int   n, k, tog, last_t, mn, mx, lead_n, h;
    int   lows [3];
    logic prev, first;
    logic [2:0] exp_cs, cs_c1;
    h = int'(div) + 1;
    n = 0;
    while (!ready && n < 2000) begin @(negedge clk); n++; end
    check({nm, ".ready_wait"}, 32'(ready), 32'd1);
    mode = m; lsb_first = lsb; clk_div = div; cs_sel = sel; tx_data = tx;
    miso_src = msrc; miso_reg = (msrc == 1);
    start = 1'b1;
    sb.push_back('{data: exp_rx, due: cyc + 1 + 18 * h});
    @(negedge clk);
    start = 1'b0;
    mode = ~m; lsb_first = ~lsb; clk_div = div + 8'd5; cs_sel = sel ^ 2'b11; tx_data = ~tx;
    cs_c1 = cs_n;
    k = 1; prev = sclk; tog = 0; last_t = 0; mn = 1 << 30; mx = 0; lead_n = 0; first = 1'b0;
    lows = '{0, 0, 0};
    while (!ready && k < 5000) begin
      for (int i = 0; i < 3; i++) if (!cs_n[i]) lows[i]++;
      if (sclk != prev) begin
        tog++;
        if (tog > 1) begin
          if (k - last_t < mn) mn = k - last_t;
          if (k - last_t > mx) mx = k - last_t;
        end
        last_t = k;
        if (tog % 2 == 1) begin
          lead_n++;
          if (lead_n == 1) first = mosi;
          if (msrc == 2 && lead_n <= 8) miso_reg = mseq[lead_n-1];
        end
      end
      prev = sclk;
      if (k == pulse_at) start = 1'b1;
      else if (k == pulse_at + 1) start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    exp_cs = 3'b111;
    if (sel < 2'd3) exp_cs[sel] = 1'b0;
    check({nm, ".frame_done"}, 32'(ready), 32'd1);
    check({nm, ".cs_cycle1"}, 32'(cs_c1), 32'(exp_cs));
    for (int i = 0; i < 3; i++)
      check($sformatf("%s.cs_low%0d", nm, i), lows[i], (exp_cs[i] == 1'b0) ? 18 * h : 0);
    check({nm, ".sclk_edges"}, tog, 16);
    check({nm, ".half_min"}, mn, h);
    check({nm, ".half_max"}, mx, h);
    check({nm, ".first_mosi"}, 32'(first), 32'(exp_first));
    check({nm, ".cs_idle"}, 32'(cs_n), 32'h7);
    check({nm, ".sclk_idle"}, 32'(sclk), 32'(m[1]));
    check({nm, ".mosi_idle"}, 32'(mosi), 32'd0);
    check({nm, ".busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   leads, n, pulses;
    logic prev;
    errors = 0; checks = 0; frames_seen = 0;
    rst = 1'b1; start = 1'b0; mode = 2'b00; lsb_first = 1'b0; clk_div = 8'd0;
    cs_sel = 2'd0; tx_data = 8'h00; miso_src = 0; miso_reg = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.cs_n", 32'(cs_n), 32'h7);
    check("rst.sclk", 32'(sclk), 32'd0);
    check("rst.mosi", 32'(mosi), 32'd0);
    check("rst.rx_valid", 32'(rx_valid), 32'd0);
    check("rst.rx_data", 32'(rx_data), 32'd0);
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    fork monitor_loop(); join_none
    @(negedge clk);

    // name          mode   lsb div   sel  tx     src seq    exp    first pulse
    run_frame("loop_m0", 2'd0, 0, 8'd0, 2'd0, 8'hA5, 0, 8'h00, 8'hA5, 1'b1, 0);
    run_frame("m3_div3", 2'd3, 0, 8'd3, 2'd0, 8'h3C, 1, 8'h00, 8'hFF, 1'b0, 0);
    run_frame("lsb_m1",  2'd1, 1, 8'd0, 2'd0, 8'h01, 2, 8'h01, 8'h01, 1'b1, 0);
    // Mid-frame start pulse must be ignored; the next frame starts in the
    // rx_valid cycle, so cs_n is high there and low again one cycle later.
    run_frame("b2b_a",   2'd0, 0, 8'd1, 2'd0, 8'h5A, 0, 8'h00, 8'h5A, 1'b0, 6);
    run_frame("b2b_b",   2'd2, 0, 8'd0, 2'd0, 8'hC3, 0, 8'h00, 8'hC3, 1'b1, 0);

    // Abort after 3 leading edges (CPOL=1, so leading edges fall).
    mode = 2'b10; lsb_first = 1'b0; clk_div = 8'd2; cs_sel = 2'd0; tx_data = 8'h81;
    miso_src = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; prev = sclk; leads = 0; n = 0;
    while (leads < 3 && n < 500) begin
      @(negedge clk);
      n++;
      if (sclk != prev && sclk == 1'b0) leads++;
      prev = sclk;
    end
    check("abort.leads", leads, 3);
    #1 rst = 1'b1;
    #1;
    check("abort.cs_n", 32'(cs_n), 32'h7);
    check("abort.sclk", 32'(sclk), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.ready", 32'(ready), 32'd1);
    check("abort.mosi", 32'(mosi), 32'd0);
    check("abort.rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (rx_valid) pulses++;
    end
    check("abort.no_rx_valid", pulses, 0);

    run_frame("post_rst", 2'd0, 0, 8'd0, 2'd0, 8'h96, 0, 8'h00, 8'h96, 1'b1, 0);
    run_frame("cs_sel1",  2'd0, 0, 8'd0, 2'd1, 8'h0F, 0, 8'h00, 8'h0F, 1'b0, 0);
    run_frame("cs_sel3",  2'd0, 0, 8'd0, 2'd3, 8'hF0, 0, 8'h00, 8'hF0, 1'b1, 0);
    run_frame("lsb_m3",   2'd3, 1, 8'd1, 2'd2, 8'h6B, 0, 8'h00, 8'h6B, 1'b1, 0);

    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("frames_seen", frames_seen, 9);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
